round_pipe: RTL

- Parametrised, pipelined successor to the combinational multiplier rounding step.
- Takes a pre-rounded mantissa with guard/sticky bits, sign, biased exponent and rounding mode. Applies the selected rounding, renormalises on carry-out, adjusts the exponent and flags exponent overflow.
- Two registered stages with valid/ready handshakes on both sides. Sits between the mantissa-product normaliser and result packing in the FP datapath, so fp_mult no longer performs the post-round exponent increment.

---
 rtl/round_pipe_if.sv | 33 +++
 rtl/round_pipe.sv | 96 +++++++++
 2 files changed

// File: rtl/round_pipe_if.sv
// Handshake and data bundle for the two-stage rounding pipeline.
// The slave modport is the rounding block; the master modport is its driver.
interface round_pipe_if #(
  parameter int MANT_W = 24,
  parameter int EXP_W  = 8
);
  logic              in_valid;
  logic              in_ready;
  logic [MANT_W-1:0] mant_in;
  logic [EXP_W-1:0]  exp_in;
  logic              guard;
  logic              sticky;
  logic              sign;
  logic [2:0]        round;
  logic              out_valid;
  logic              out_ready;
  logic [MANT_W-1:0] mant_out;
  logic [EXP_W-1:0]  exp_out;
  logic              sign_out;
  logic              inexact;
  logic              carry;
  logic              ovf;

  modport master (
    output in_valid, mant_in, exp_in, guard, sticky, sign, round, out_ready,
    input  in_ready, out_valid, mant_out, exp_out, sign_out, inexact, carry, ovf
  );

  modport slave (
    input  in_valid, mant_in, exp_in, guard, sticky, sign, round, out_ready,
    output in_ready, out_valid, mant_out, exp_out, sign_out, inexact, carry, ovf
  );
endinterface

// File: rtl/round_pipe.sv
// Pipelined FP rounding step: S1 applies the rounding increment, S2 renormalises
// on carry-out and adjusts/saturates the exponent. Valid/ready on both sides.
module round_pipe #(
  parameter int MANT_W = 24,
  parameter int EXP_W  = 8
) (
  input  logic        clk,
  input  logic        rst,
  round_pipe_if.slave io
);
  localparam logic [2:0] IEEE_NEAR = 3'd0;
  localparam logic [2:0] IEEE_ZERO = 3'd1;
  localparam logic [2:0] IEEE_PINF = 3'd2;
  localparam logic [2:0] IEEE_NINF = 3'd3;
  localparam logic [2:0] NEAR_UP   = 3'd4;
  localparam logic [2:0] AWAY_ZERO = 3'd5;

  typedef struct packed {
    logic [MANT_W:0]  sum;
    logic [EXP_W-1:0] exp;
    logic             sign;
    logic             inexact;
  } s1_t;

  s1_t              s1_q, s1_d;
  logic             s1_valid, s2_valid;
  logic             s1_ld, s2_ld;
  logic             inc, gs;
  logic [EXP_W:0]   exp_sum;
  logic             ovf_d;
  logic [MANT_W-1:0] mant_d;

  assign gs = io.guard | io.sticky;

  always_comb begin
    inc = io.guard & (io.sticky | io.mant_in[0]);
    case (io.round)
      IEEE_NEAR: inc = io.guard & (io.sticky | io.mant_in[0]);
      IEEE_ZERO: inc = 1'b0;
      IEEE_PINF: inc = ~io.sign & gs;
      IEEE_NINF: inc = io.sign & gs;
      NEAR_UP:   inc = io.guard;
      AWAY_ZERO: inc = gs;
      default:   inc = io.guard & (io.sticky | io.mant_in[0]);
    endcase
  end

  always_comb begin
    s1_d         = '0;
    s1_d.sum     = {1'b0, io.mant_in} + {{MANT_W{1'b0}}, inc};
    s1_d.exp     = io.exp_in;
    s1_d.sign    = io.sign;
    s1_d.inexact = gs;
  end

  // Carry-out means the sum is exactly 2^MANT_W, so a right shift renormalises it.
  assign mant_d  = s1_q.sum[MANT_W] ? s1_q.sum[MANT_W:1] : s1_q.sum[MANT_W-1:0];
  assign exp_sum = {1'b0, s1_q.exp} + {{EXP_W{1'b0}}, s1_q.sum[MANT_W]};
  assign ovf_d   = exp_sum >= {1'b0, {EXP_W{1'b1}}};

  assign s2_ld       = ~s2_valid | io.out_ready;
  assign s1_ld       = ~s1_valid | s2_ld;
  assign io.in_ready = ~s1_valid | ~s2_valid | io.out_ready;
  assign io.out_valid = s2_valid;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid    <= 1'b0;
      s2_valid    <= 1'b0;
      s1_q        <= '0;
      io.mant_out <= '0;
      io.exp_out  <= '0;
      io.sign_out <= 1'b0;
      io.inexact  <= 1'b0;
      io.carry    <= 1'b0;
      io.ovf      <= 1'b0;
    end else begin
      if (s1_ld) begin
        s1_valid <= io.in_valid;
        if (io.in_valid) s1_q <= s1_d;
      end
      // Output registers only change on a real S2 load, so they hold under backpressure.
      if (s2_ld) begin
        s2_valid <= s1_valid;
        if (s1_valid) begin
          io.mant_out <= mant_d;
          io.exp_out  <= ovf_d ? {EXP_W{1'b1}} : exp_sum[EXP_W-1:0];
          io.sign_out <= s1_q.sign;
          io.inexact  <= s1_q.inexact;
          io.carry    <= s1_q.sum[MANT_W];
          io.ovf      <= ovf_d;
        end
      end
    end
  end
endmodule
